cpu_control_seq: RTL and testbench

Fetch/execute control sequencer for the 2-bit computer. It owns the program counter, instruction register, the A and B data registers and the carry flag.
- Drives the instruction-ROM address.
- Steps through a 2-cycle fetch/execute loop after a Start pulse.
- Loads the data registers, which are the writer side of the flip-flop storage.

---
 rtl/cpu_control_seq_pkg.sv | 22 ++
 rtl/cpu_control_seq_alu_add2.sv | 13 +
 rtl/cpu_control_seq.sv | 116 +++++++++++
 tb/tb_cpu_control_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_seq_pkg.sv
// Shared opcode and state encodings for the 2-bit computer control sequencer.
package cpu_control_seq_pkg;

    localparam logic [1:0] OP_LDA      = 2'b00;
    localparam logic [1:0] OP_LDB      = 2'b01;
    localparam logic [1:0] OP_ADD      = 2'b10;
    localparam logic [1:0] OP_JMP      = 2'b11;
    localparam logic [1:0] HLT_OPERAND = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    // HLT shares the JMP opcode; the all-ones operand marks it.
    function automatic logic is_hlt(input logic [3:0] ir);
        return (ir[3:2] == OP_JMP) && (ir[1:0] == HLT_OPERAND);
    endfunction

endpackage

// File: rtl/cpu_control_seq_alu_add2.sv
// DATA_W-bit adder with carry-out, used by the ADD instruction.
module alu_add2 #(
    parameter int unsigned DATA_W = 2
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/cpu_control_seq.sv
// Fetch/execute sequencer: owns PC, IR, A, B and Carry; one instruction per two cycles.
module cpu_control_seq
    import cpu_control_seq_pkg::*;
#(
    parameter int unsigned PC_W   = 2,
    parameter int unsigned DATA_W = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [3:0]        Instr,
    output logic [PC_W-1:0]   Addr,
    output logic [DATA_W-1:0] A_Out,
    output logic [DATA_W-1:0] B_Out,
    output logic              Carry,
    output logic              Busy,
    output logic              Halted,
    output logic [1:0]        State
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [3:0]        ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] sum;
    logic              sum_carry;

    alu_add2 #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a    (a_q),
        .b    (b_q),
        .sum  (sum),
        .carry(sum_carry)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (Start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = is_hlt(ir_q) ? ST_HALT : ST_FETCH;
            ST_HALT:  if (Start) state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        State  = state_q;
        Busy   = (state_q == ST_FETCH) || (state_q == ST_EXEC);
        Halted = (state_q == ST_HALT);
    end

    // Datapath registers update only from the state in which their write is decoded.
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        unique case (state_q)
            ST_IDLE:  ;
            ST_FETCH: ir_d = Instr;
            ST_EXEC: begin
                unique case (ir_q[3:2])
                    OP_LDA: begin
                        a_d  = DATA_W'(ir_q[1:0]);
                        pc_d = pc_q + PC_W'(1);
                    end
                    OP_LDB: begin
                        b_d  = DATA_W'(ir_q[1:0]);
                        pc_d = pc_q + PC_W'(1);
                    end
                    OP_ADD: begin
                        a_d     = sum;
                        carry_d = sum_carry;
                        pc_d    = pc_q + PC_W'(1);
                    end
                    OP_JMP: if (!is_hlt(ir_q)) pc_d = PC_W'(ir_q[1:0]);
                endcase
            end
            ST_HALT:  if (Start) pc_d = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
        end
    end

    assign Addr  = pc_q;
    assign A_Out = a_q;
    assign B_Out = b_q;
    assign Carry = carry_q;

endmodule

// File: tb/tb_cpu_control_seq.sv
// Scoreboard bench: each retired instruction is checked against a queued expected snapshot.
module tb_cpu_control_seq;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Start;
    logic [3:0] Instr;
    logic [1:0] Addr;
    logic [1:0] A_Out;
    logic [1:0] B_Out;
    logic       Carry;
    logic       Busy;
    logic       Halted;
    logic [1:0] State;

    logic [3:0] rom [4];
    logic       corrupt;

    typedef struct packed {
        logic [1:0] addr;
        logic [1:0] a;
        logic [1:0] b;
        logic       carry;
        logic       busy;
        logic       halted;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    cpu_control_seq #(
        .PC_W  (2),
        .DATA_W(2)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .Start (Start),
        .Instr (Instr),
        .Addr  (Addr),
        .A_Out (A_Out),
        .B_Out (B_Out),
        .Carry (Carry),
        .Busy  (Busy),
        .Halted(Halted),
        .State (State)
    );

    always #5 CLK = ~CLK;

    // ROM model; optionally scrambles the word while the DUT is in EXEC.
    always_comb begin
        Instr = rom[Addr];
        if (corrupt && State == 2'b10) Instr = ~rom[Addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic push(input logic [1:0] addr, input logic [1:0] a, input logic [1:0] b,
                        input logic c, input logic h);
        exp_t e;
        e.addr   = addr;
        e.a      = a;
        e.b      = b;
        e.carry  = c;
        e.busy   = !h;
        e.halted = h;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2,
                        input logic [3:0] w3);
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
    endtask

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor: an instruction has retired when the state leaves EXEC for FETCH or HALT.
    logic [1:0] prev_state = 2'b00;
    always @(negedge CLK) begin
        exp_t e;
        if (Reset) begin
            prev_state = 2'b00;
        end else begin
            if (prev_state == 2'b10 && (State == 2'b01 || State == 2'b11)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL retire: unexpected retirement at addr %0d (t=%0t)", Addr, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("ret_addr", Addr, e.addr);
                    check("ret_a", A_Out, e.a);
                    check("ret_b", B_Out, e.b);
                    check("ret_carry", Carry, e.carry);
                    check("ret_busy", Busy, e.busy);
                    check("ret_halted", Halted, e.halted);
                end
            end
            prev_state = State;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int found;
        int first_h;
        int second_h;
        int nh;
        Reset   = 1'b1;
        Start   = 1'b0;
        corrupt = 1'b0;

        // Test 1: reset in EXEC of LDA 2 after A was loaded with 1.
        load(4'b0001, 4'b0010, 4'b1111, 4'b1111);
        cyc();
        cyc();
        check("rst_state", State, 0);
        check("rst_addr", Addr, 0);
        check("rst_a", A_Out, 0);
        check("rst_b", B_Out, 0);
        check("rst_carry", Carry, 0);
        check("rst_busy", Busy, 0);
        check("rst_halted", Halted, 0);
        Reset = 1'b0;
        cyc();
        check("idle_hold", State, 0);
        push(2'd1, 2'd1, 2'd0, 1'b0, 1'b0);
        pulse_start();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (State == 2'b10 && Addr == 2'd1) found = 1;
            else cyc();
        end
        check("t1_reach_exec", found, 1);
        check("t1_a_before", A_Out, 1);
        Reset = 1'b1;
        #1;
        check("t1_async_a", A_Out, 0);
        check("t1_async_pc", Addr, 0);
        check("t1_async_state", State, 0);
        check("t1_async_busy", Busy, 0);
        check("t1_async_carry", Carry, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t1_a_not_2", A_Out, 0);
        end
        check("t1_queue", exp_q.size(), 0);

        // Test 3: ADD/JMP loop, A goes 2,3,0(C=1),1(C=0).
        load(4'b0001, 4'b0101, 4'b1000, 4'b1110);
        Reset = 1'b0;
        push(2'd1, 2'd1, 2'd0, 1'b0, 1'b0);
        push(2'd2, 2'd1, 2'd1, 1'b0, 1'b0);
        push(2'd3, 2'd2, 2'd1, 1'b0, 1'b0);
        push(2'd2, 2'd2, 2'd1, 1'b0, 1'b0);
        push(2'd3, 2'd3, 2'd1, 1'b0, 1'b0);
        push(2'd2, 2'd3, 2'd1, 1'b0, 1'b0);
        push(2'd3, 2'd0, 2'd1, 1'b1, 1'b0);
        push(2'd2, 2'd0, 2'd1, 1'b1, 1'b0);
        push(2'd3, 2'd1, 2'd1, 1'b0, 1'b0);
        push(2'd2, 2'd1, 2'd1, 1'b0, 1'b0);
        pulse_start();
        drain(60);
        Reset = 1'b1;
        cyc();

        // Test 4: no HLT, PC wraps; Instr scrambled during EXEC must be ignored.
        load(4'b0001, 4'b0100, 4'b0010, 4'b0110);
        corrupt = 1'b1;
        Reset   = 1'b0;
        push(2'd1, 2'd1, 2'd0, 1'b0, 1'b0);
        push(2'd2, 2'd1, 2'd0, 1'b0, 1'b0);
        push(2'd3, 2'd2, 2'd0, 1'b0, 1'b0);
        push(2'd0, 2'd2, 2'd2, 1'b0, 1'b0);
        push(2'd1, 2'd1, 2'd2, 1'b0, 1'b0);
        push(2'd2, 2'd1, 2'd0, 1'b0, 1'b0);
        pulse_start();
        drain(40);
        Reset   = 1'b1;
        corrupt = 1'b0;
        cyc();

        // Test 2: 3+3 -> A=2, Carry=1, then HLT.
        load(4'b0011, 4'b0111, 4'b1000, 4'b1111);
        Reset = 1'b0;
        push(2'd1, 2'd3, 2'd0, 1'b0, 1'b0);
        push(2'd2, 2'd3, 2'd3, 1'b0, 1'b0);
        push(2'd3, 2'd2, 2'd3, 1'b1, 1'b0);
        push(2'd3, 2'd2, 2'd3, 1'b1, 1'b1);
        pulse_start();
        drain(30);
        check("t2_halted", Halted, 1);
        check("t2_addr", Addr, 3);

        // Test 5: HALT holds without Start, restart keeps A/B/Carry.
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t5_halted", Halted, 1);
            check("t5_a", A_Out, 2);
            check("t5_addr", Addr, 3);
        end
        push(2'd1, 2'd3, 2'd3, 1'b1, 1'b0);
        push(2'd2, 2'd3, 2'd3, 1'b1, 1'b0);
        push(2'd3, 2'd2, 2'd3, 1'b1, 1'b0);
        push(2'd3, 2'd2, 2'd3, 1'b1, 1'b1);
        Start = 1'b1;
        cyc();
        check("t5_fetch", State, 1);
        check("t5_pc0", Addr, 0);
        check("t5_carry_kept", Carry, 1);
        Start = 1'b0;
        drain(30);

        // Test 6: Start held high: HALT lasts one cycle, period of nine cycles.
        for (int p = 0; p < 2; p++) begin
            push(2'd1, 2'd3, 2'd3, 1'b1, 1'b0);
            push(2'd2, 2'd3, 2'd3, 1'b1, 1'b0);
            push(2'd3, 2'd2, 2'd3, 1'b1, 1'b0);
            push(2'd3, 2'd2, 2'd3, 1'b1, 1'b1);
        end
        Start    = 1'b1;
        first_h  = -1;
        second_h = -1;
        nh       = 0;
        for (int c = 0; c < 19; c++) begin
            cyc();
            if (Halted) begin
                nh++;
                if (first_h < 0) first_h = c;
                else if (second_h < 0) second_h = c;
            end
        end
        check("t6_first_halt", first_h, 8);
        check("t6_second_halt", second_h, 17);
        check("t6_halt_cycles", nh, 2);
        Start = 1'b0;
        Reset = 1'b1;
        cyc();
        check("t6_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
